// File: rtl/dmem_responder_pkg.sv
// Shared core package: data-memory responder FSM state encoding and response constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_responder_pkg;

  // IDLE: nothing pending; GNT_WAIT: counting wait states before grant; RESP: data_valid high.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } dmem_state_e;

  // Read-data value presented alongside a write response.
  localparam logic [31:0] DMEM_WR_RDATA = 32'h0;

endpackage

// File: rtl/sram_1rw.sv
// Single-port WORDS x 32 SRAM, byte-enabled write, synchronous read-first.
// Latency: read data appears on rdata the cycle after re; write commits at the same edge.
// Backpressure: none; always accepts one access per cycle. Contents are never reset.
module sram_1rw #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q, rdata_d;

  // Capture the addressed word on a read; hold otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  // Read register; old word is sampled before a same-edge write lands.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  // Byte-lane write into the array.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: grants core requests and returns one response pulse per accept.
// Latency: data_valid one cycle after the accepting edge; one transaction per cycle sustained.
// Backpressure: data_gnt gates acceptance; optional wait states via macro DMEM_WAIT_STATE_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_WORDS   = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteen,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_valid
);

  localparam int         AW     = $clog2(MEM_WORDS);
  localparam logic [3:0] WAIT_Q = 4'(WAIT_CYCLES);

  dmem_state_e   state_q, state_d;
  logic          wr_q, wr_d;
  logic          accept;
  logic [AW-1:0] word_idx;
  logic [31:0]   sram_rdata;

  // Byte address bits [1:0] and bits above the array depth are dropped, so addresses wrap.
  assign word_idx = data_addr[AW+1:2];
  assign accept   = data_req & data_gnt;

`ifdef DMEM_WAIT_STATE_EN
  logic [3:0] cnt_q, cnt_d;
  logic       unused_addr;
  assign unused_addr = ^{data_addr[31:AW+2], data_addr[1:0]};

  // Grant once the request has been held for WAIT_CYCLES cycles; never during reset.
  always_comb begin
    data_gnt = 1'b0;
    if (reset_n && data_req) begin
      if (WAIT_Q == 4'd0)                                data_gnt = 1'b1;
      else if (state_q == ST_GNT_WAIT && cnt_q == WAIT_Q) data_gnt = 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{data_addr[31:AW+2], data_addr[1:0], WAIT_Q};
  assign data_gnt   = reset_n & data_req;
`endif

  // Next-state: accept always leads to RESP; unaccepted requests count wait states.
  always_comb begin
    state_d = ST_IDLE;
    wr_d    = data_wr;
`ifdef DMEM_WAIT_STATE_EN
    cnt_d   = 4'd0;
`endif
    if (accept) begin
      state_d = ST_RESP;
    end else begin
`ifdef DMEM_WAIT_STATE_EN
      // A dropped request falls back to IDLE with the counter cleared.
      if (data_req && WAIT_Q != 4'd0) begin
        state_d = ST_GNT_WAIT;
        cnt_d   = (state_q == ST_GNT_WAIT) ? cnt_q + 4'd1 : 4'd1;
      end
`endif
      wr_d = wr_q;
    end
  end

  // State registers with synchronous active-low reset; pending responses are dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
`ifdef DMEM_WAIT_STATE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign data_valid = (state_q == ST_RESP);
  assign data_rdata = (data_valid && !wr_q) ? sram_rdata : DMEM_WR_RDATA;

  sram_1rw #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .we    (accept & data_wr),
    .re    (accept & ~data_wr),
    .addr  (word_idx),
    .wdata (data_wdata),
    .be    (data_byteen),
    .rdata (sram_rdata)
  );

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096 (power of 2): word depth of backing memory.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2 (range 0..15): grant delay in cycles; used only when DMEM_WAIT_STATE_EN is defined.
REQ-003 SHALL have clk  input  1  the single clock.
REQ-004 SHALL have reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have data_req  input  1  request from core; held high until granted.
REQ-006 SHALL have data_wr  input  1  1 = write, 0 = read; qualified by data_req.
REQ-007 SHALL have data_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have data_wdata  input  32  write data.
REQ-009 SHALL have data_byteen  input  4  write byte lanes; bit n enables wdata[8n+7:8n].
REQ-010 SHALL have data_gnt  output  1  address-phase accept.
REQ-011 SHALL have data_rdata  output  32  read data; valid only with data_valid.
REQ-012 SHALL have data_valid  output  1  one-cycle response pulse per accepted request.

Function
REQ-013 Acceptance: a request SHALL be accepted on a rising edge where data_req && data_gnt.
REQ-014 Word index SHALL be data_addr[log2(MEM_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*MEM_WORDS.
REQ-015 Without wait states, data_gnt SHALL equal data_req combinationally in IDLE and RESP states.
REQ-016 data_valid SHALL assert exactly one cycle after acceptance, for one cycle, for both reads and writes.
REQ-017 Read response: data_rdata SHALL be the full addressed word before any same-cycle write; all 4 bytes are returned regardless of data_byteen.
REQ-018 Write response: only enabled byte lanes SHALL be updated at the acceptance edge; data_rdata SHALL be 32'h0 with data_valid.
REQ-019 Responses SHALL be in order; at most one response SHALL be outstanding.
REQ-020 Back-to-back: a new request SHALL be grantable in the same cycle data_valid is high for the previous one, sustaining one transaction per cycle.
REQ-021 Read after write to the same word on consecutive cycles SHALL return the newly written bytes.
REQ-022 FSM states: IDLE (no response pending), GNT_WAIT (counting wait states; macro builds only), RESP (data_valid high).
REQ-023 Transitions: IDLE->RESP on accept; IDLE->GNT_WAIT on data_req with WAIT_CYCLES>0; GNT_WAIT->RESP on accept; RESP->RESP on accept; RESP->IDLE with no accept.
REQ-024 If data_req drops in GNT_WAIT (protocol violation), FSM SHALL return to IDLE, clear the counter, and issue no response or write.
REQ-025 data_gnt SHALL be 0 whenever reset_n is low.

Reset
REQ-026 At the first clk edge with reset_n low: state=IDLE, data_valid=0, data_rdata=0, wait counter=0; memory contents SHALL NOT be cleared.
REQ-027 Reset mid-transaction SHALL drop any pending response; a write accepted at the reset edge SHALL NOT be committed.

Configuration
REQ-028 Macro DMEM_WAIT_STATE_EN: when defined, data_gnt SHALL assert only after data_req has been high for WAIT_CYCLES consecutive cycles (GNT_WAIT counting); WAIT_CYCLES=0 SHALL behave as without the macro.
REQ-029 When DMEM_WAIT_STATE_EN is undefined, GNT_WAIT and the counter SHALL NOT be built, and REQ-015 applies.

Structure
REQ-030 The FSM state enum (dmem_state_e) and the 32'h0 write-response constant SHALL live in the shared core package.
REQ-031 The memory array SHALL be one sub-module, sram_1rw: single-port, byte-enabled write, synchronous read, MEM_WORDS x 32.

Verification
REQ-032 Write addr 0x10, wdata 0xA5A5_1234, byteen 0xF, then read 0x10 -> data_gnt same cycle as req, data_valid 1 cycle after each accept, read rdata 0xA5A5_1234.
REQ-033 Pre-write 0x1122_3344 at 0x20, write 0xFFFF_FFFF with byteen 0x5, read 0x20 -> rdata 0x11FF_33FF.
REQ-034 Read 0x0, 0x4, 0x8 on 3 consecutive cycles with req held -> 3 grants in 3 cycles, 3 valid pulses in order, no bubbles.
REQ-035 MEM_WORDS=4096: write 0x0000_0004, read 0x0000_4004 -> wrapped data returned.
REQ-036 DMEM_WAIT_STATE_EN, WAIT_CYCLES=3: req at cycle 0 -> gnt at cycle 3, valid at cycle 4; req dropped at cycle 1 -> no gnt, no valid, memory unchanged.
REQ-037 Assert reset_n low in the cycle after a write accept -> data_valid 0 on the next cycle; memory retains pre-reset contents.
